wb_protocol_monitor: RTL and testbench

WB_PROTOCOL_MONITOR -- requirements
Module: wb_protocol_monitor

---
 rtl/wb_protocol_monitor.sv | 180 ++++++++++++++++++
 tb/tb_wb_protocol_monitor.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_protocol_monitor.sv
// wb_protocol_monitor: passive observer of a Wishbone classic-cycle slave port.
// It counts completed reads and writes, measures strobe-to-ack latency, and
// keeps sticky protocol error flags. It never drives the bus.
// Optional watchdog: define WB_MON_TIMEOUT_EN to abandon transfers that wait
// TIMEOUT_CYCLES without an ack and raise err_flags[4].
module wb_protocol_monitor #(
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned LAT_W          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [3:0]       wb_sel_i,
  input  logic             wb_ack_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] wr_count,
  output logic [CNT_W-1:0] rd_count,
  output logic [LAT_W-1:0] last_lat,
  output logic [LAT_W-1:0] max_lat,
  output logic             busy,
  output logic [4:0]       err_flags,
  output logic             err_any
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  state_t           state;
  logic             cap_we;
  logic [3:0]       cap_sel;
  logic [LAT_W-1:0] lat_cnt;
  logic [3:0]       err_reg;
  logic             err_to;

  logic             req;
  logic             done;
  logic             done_we;
  logic [LAT_W-1:0] done_lat;
  logic             leave_wait;
  logic [3:0]       err_set;

  assign req = wb_cyc_i & wb_stb_i;

`ifdef WB_MON_TIMEOUT_EN
  // The latency counter saturates at 2^LAT_W-1, which may be below the
  // timeout period, so the watchdog keeps its own unsaturated wait count.
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            timeout;

  assign timeout = (state == WAIT_ACK) && req && !wb_ack_i &&
                   (wd_cnt == WD_W'(TIMEOUT_CYCLES));

  // Watchdog wait counter and its sticky timeout flag.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wd_cnt <= '0;
      err_to <= 1'b0;
    end else begin
      if (state == IDLE) begin
        wd_cnt <= WD_W'(1);
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (clr_i) begin
        err_to <= 1'b0;
      end else if (timeout) begin
        err_to <= 1'b1;
      end
    end
  end
`else
  // Keeps the watchdog-period parameter referenced when the watchdog is absent.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign err_to             = 1'b0;
`endif

  // Classify the current edge: completion, abandonment and error events.
  always_comb begin
    done       = 1'b0;
    done_we    = 1'b0;
    done_lat   = '0;
    leave_wait = 1'b0;
    err_set    = '0;
    err_set[0] = wb_ack_i & ~req;
    if (state == IDLE) begin
      if (req) begin
        err_set[3] = (wb_sel_i == 4'h0);
        if (wb_ack_i) begin
          done    = 1'b1;
          done_we = wb_we_i;
        end
      end
    end else begin
      err_set[2] = (wb_we_i != cap_we) || (wb_sel_i != cap_sel);
      if (req && wb_ack_i) begin
        done       = 1'b1;
        done_we    = cap_we;
        done_lat   = lat_cnt;
        leave_wait = 1'b1;
      end else if (!req) begin
        err_set[1] = 1'b1;
        leave_wait = 1'b1;
      end
`ifdef WB_MON_TIMEOUT_EN
      else if (timeout) begin
        leave_wait = 1'b1;
      end
`endif
    end
  end

  // FSM, attribute capture, latency counter and registered statistics.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      cap_we   <= 1'b0;
      cap_sel  <= '0;
      lat_cnt  <= '0;
      wr_count <= '0;
      rd_count <= '0;
      last_lat <= '0;
      max_lat  <= '0;
      err_reg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req && !wb_ack_i) begin
            state   <= WAIT_ACK;
            cap_we  <= wb_we_i;
            cap_sel <= wb_sel_i;
            lat_cnt <= LAT_W'(1);
          end
        end
        WAIT_ACK: begin
          if (leave_wait) begin
            state <= IDLE;
          end else if (lat_cnt != '1) begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // A clear overrides a coincident completion except for its latency.
      if (clr_i) begin
        wr_count <= '0;
        rd_count <= '0;
        max_lat  <= '0;
        err_reg  <= '0;
        last_lat <= done ? done_lat : '0;
      end else begin
        if (done) begin
          last_lat <= done_lat;
          if (done_lat > max_lat) begin
            max_lat <= done_lat;
          end
          if (done_we) begin
            wr_count <= wr_count + 1'b1;
          end else begin
            rd_count <= rd_count + 1'b1;
          end
        end
        err_reg <= err_reg | err_set;
      end
    end
  end

  assign busy      = (state == WAIT_ACK);
  assign err_flags = {err_to, err_reg};
  assign err_any   = |err_flags;

endmodule

// File: tb/tb_wb_protocol_monitor.sv
// tb_wb_protocol_monitor: directed scenarios plus randomized bus traffic,
// checked every cycle against a timestamp-based reference model.
module tb_wb_protocol_monitor;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned LAT_W   = 4;
  localparam int unsigned TO      = 16;
  localparam int          CNT_MOD = 1 << CNT_W;
  localparam int          LAT_MAX = (1 << LAT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cyc = 1'b0;
  logic             stb = 1'b0;
  logic             we  = 1'b0;
  logic [3:0]       sel = '0;
  logic             ack = 1'b0;
  logic             clr = 1'b0;
  logic [CNT_W-1:0] wr_count;
  logic [CNT_W-1:0] rd_count;
  logic [LAT_W-1:0] last_lat;
  logic [LAT_W-1:0] max_lat;
  logic             busy;
  logic [4:0]       err_flags;
  logic             err_any;

  always #5 clk = ~clk;

  wb_protocol_monitor #(
    .CNT_W          (CNT_W),
    .LAT_W          (LAT_W),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wb_cyc_i  (cyc),
    .wb_stb_i  (stb),
    .wb_we_i   (we),
    .wb_sel_i  (sel),
    .wb_ack_i  (ack),
    .clr_i     (clr),
    .wr_count  (wr_count),
    .rd_count  (rd_count),
    .last_lat  (last_lat),
    .max_lat   (max_lat),
    .busy      (busy),
    .err_flags (err_flags),
    .err_any   (err_any)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: an outstanding request is remembered by the edge number
  // at which it was first seen; latency is the edge-number difference.
  int       edge_no  = 0;
  bit       m_active = 1'b0;
  int       m_start  = 0;
  bit       m_we     = 1'b0;
  bit [3:0] m_sel    = '0;
  int       m_wr     = 0;
  int       m_rd     = 0;
  int       m_last   = 0;
  int       m_max    = 0;
  bit [4:0] m_err    = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit c, s, w, input bit [3:0] sl, input bit a, cl, r);
    bit       rq;
    bit       done;
    bit       dwe;
    int       dlat;
    int       waited;
    bit [4:0] e;
    rq   = c & s;
    done = 1'b0;
    dwe  = 1'b0;
    dlat = 0;
    e    = '0;
    if (r) begin
      m_active = 1'b0;
      m_wr = 0; m_rd = 0; m_last = 0; m_max = 0; m_err = '0;
      return;
    end
    if (a && !rq) e[0] = 1'b1;
    if (m_active) begin
      waited = edge_no - m_start;
      if (w != m_we || sl != m_sel) e[2] = 1'b1;
      if (rq && a) begin
        done     = 1'b1;
        dwe      = m_we;
        dlat     = (waited > LAT_MAX) ? LAT_MAX : waited;
        m_active = 1'b0;
      end else if (!rq) begin
        e[1]     = 1'b1;
        m_active = 1'b0;
      end
`ifdef WB_MON_TIMEOUT_EN
      else if (waited >= TO) begin
        e[4]     = 1'b1;
        m_active = 1'b0;
      end
`endif
    end else if (rq) begin
      if (sl == 4'h0) e[3] = 1'b1;
      if (a) begin
        done = 1'b1;
        dwe  = w;
        dlat = 0;
      end else begin
        m_active = 1'b1;
        m_start  = edge_no;
        m_we     = w;
        m_sel    = sl;
      end
    end
    if (cl) begin
      m_wr = 0; m_rd = 0; m_max = 0; m_err = '0;
      m_last = done ? dlat : 0;
    end else begin
      if (done) begin
        m_last = dlat;
        if (dlat > m_max) m_max = dlat;
        if (dwe) m_wr = (m_wr + 1) % CNT_MOD;
        else     m_rd = (m_rd + 1) % CNT_MOD;
      end
      m_err = m_err | e;
    end
  endtask

  // Drive one cycle, advance the model on the edge, compare 1 time unit later.
  task automatic cycle(input bit c, s, w, input bit [3:0] sl, input bit a, cl, r);
    cyc = c; stb = s; we = w; sel = sl; ack = a; clr = cl; rst = r;
    @(posedge clk);
    edge_no++;
    model_step(c, s, w, sl, a, cl, r);
    #1;
    check("wr_count",  wr_count,  m_wr);
    check("rd_count",  rd_count,  m_rd);
    check("last_lat",  last_lat,  m_last);
    check("max_lat",   max_lat,   m_max);
    check("busy",      busy,      m_active);
    check("err_flags", err_flags, m_err);
    check("err_any",   err_any,   |m_err);
  endtask

  task automatic idle();
    cycle(0, 0, 0, 4'h0, 0, 0, 0);
  endtask

  task automatic clear();
    cycle(0, 0, 0, 4'h0, 0, 1, 0);
  endtask

  bit       r_req;
  bit       r_we;
  bit [3:0] r_sel;
  bit       r_c, r_s, r_a, r_cl, r_r;
  int       p_ack, p_drop;

  initial begin
    // Reset state
    cycle(1, 1, 1, 4'hF, 0, 0, 1);
    cycle(0, 0, 0, 4'h0, 0, 0, 1);
    check("rst_wr",   wr_count,  0);
    check("rst_busy", busy,      0);
    check("rst_err",  err_flags, 0);

    // Write acked three cycles after the strobe
    cycle(0, 0, 0, 4'h0, 0, 0, 0);
    repeat (3) cycle(1, 1, 1, 4'hF, 0, 0, 0);
    cycle(1, 1, 1, 4'hF, 1, 0, 0);
    idle();
    check("wr3_wr",   wr_count, 1);
    check("wr3_last", last_lat, 3);
    check("wr3_max",  max_lat,  3);
    check("wr3_any",  err_any,  0);

    // Zero-latency read, back-to-back read of latency 5
    clear();
    cycle(1, 1, 0, 4'hF, 1, 0, 0);
    repeat (5) cycle(1, 1, 0, 4'hF, 0, 0, 0);
    cycle(1, 1, 0, 4'hF, 1, 0, 0);
    idle();
    check("rd5_rd",   rd_count, 2);
    check("rd5_last", last_lat, 5);
    check("rd5_max",  max_lat,  5);

    // Strobe dropped, then a stray ack
    clear();
    repeat (2) cycle(1, 1, 0, 4'hF, 0, 0, 0);
    cycle(0, 0, 0, 4'hF, 0, 0, 0);
    cycle(0, 0, 0, 4'hF, 1, 0, 0);
    idle();
    check("drop_err", err_flags, 5'b00011);
    check("drop_wr",  wr_count,  0);
    check("drop_rd",  rd_count,  0);

    // Clear coinciding with a completion keeps only the latency
    clear();
    repeat (2) cycle(1, 1, 1, 4'hF, 0, 0, 0);
    cycle(1, 1, 1, 4'hF, 1, 1, 0);
    check("clrdone_last", last_lat, 2);
    check("clrdone_wr",   wr_count, 0);
    check("clrdone_max",  max_lat,  0);
    idle();

    // Latency saturation: ack on the 16th cycle after the strobe
    clear();
    repeat (16) cycle(1, 1, 0, 4'h3, 0, 0, 0);
    cycle(1, 1, 0, 4'h3, 1, 0, 0);
    idle();
    check("sat_last", last_lat, LAT_MAX);
    check("sat_max",  max_lat,  LAT_MAX);
    check("sat_rd",   rd_count, 1);

`ifdef WB_MON_TIMEOUT_EN
    // Watchdog expiry
    clear();
    repeat (16) cycle(1, 1, 1, 4'hF, 0, 0, 0);
    check("to_busy_pre", busy, 1);
    cycle(1, 1, 1, 4'hF, 0, 0, 0);
    check("to_err4", err_flags[4], 1);
    check("to_busy", busy,         0);
    check("to_wr",   wr_count,     0);
    idle();
`else
    // No watchdog: a long wait persists until acked
    clear();
    repeat (30) cycle(1, 1, 1, 4'hF, 0, 0, 0);
    check("long_busy", busy,      1);
    check("long_err",  err_flags, 0);
    cycle(1, 1, 1, 4'hF, 1, 0, 0);
    check("long_wr",   wr_count,  1);
    check("long_last", last_lat,  LAT_MAX);
    idle();
`endif

    // Reset mid-transfer, then sel==0 request, then clear
    repeat (2) cycle(1, 1, 1, 4'hF, 0, 0, 0);
    cycle(1, 1, 1, 4'hF, 0, 0, 1);
    check("midrst_wr",   wr_count,  0);
    check("midrst_last", last_lat,  0);
    check("midrst_busy", busy,      0);
    check("midrst_err",  err_flags, 0);
    cycle(1, 1, 0, 4'h0, 1, 0, 0);
    check("sel0_err", err_flags, 5'b01000);
    check("sel0_rd",  rd_count,  1);
    clear();
    check("sel0_clr", err_flags, 0);

    // Attribute change while waiting
    repeat (1) cycle(1, 1, 1, 4'hF, 0, 0, 0);
    cycle(1, 1, 1, 4'h3, 0, 0, 0);
    cycle(1, 1, 1, 4'h3, 1, 0, 0);
    idle();
    check("attr_err",  err_flags, 5'b00100);
    check("attr_wr",   wr_count,  1);
    check("attr_last", last_lat,  2);

    // Randomized traffic in segments with varying ack/drop rates
    r_req = 1'b0;
    r_we  = 1'b0;
    r_sel = 4'hF;
    for (int seg = 0; seg < 100; seg++) begin
      case ($urandom_range(2))
        0:       begin p_ack = 50; p_drop = 10; end
        1:       begin p_ack = 15; p_drop = 4;  end
        default: begin p_ack = 2;  p_drop = 1;  end
      endcase
      for (int k = 0; k < 30; k++) begin
        if (r_req) begin
          if ($urandom_range(99) < p_drop) r_req = 1'b0;
        end else if ($urandom_range(99) < 60) begin
          r_req = 1'b1;
          r_we  = $urandom_range(1) == 1;
          r_sel = ($urandom_range(9) == 0) ? 4'h0 : 4'($urandom_range(15));
        end
        if ($urandom_range(99) < 3) r_we  = ~r_we;
        if ($urandom_range(99) < 3) r_sel = 4'($urandom_range(15));
        if (r_req) begin
          r_c = 1'b1;
          r_s = 1'b1;
        end else begin
          r_c = $urandom_range(3) == 0;
          r_s = $urandom_range(3) == 0;
          if (r_c && r_s) r_s = 1'b0;
        end
        r_a  = $urandom_range(99) < p_ack;
        if (!r_req && r_a && $urandom_range(3) != 0) r_a = 1'b0;
        r_cl = $urandom_range(99) < 3;
        r_r  = $urandom_range(99) < 1;
        cycle(r_c, r_s, r_we, r_sel, r_a, r_cl, r_r);
        if (r_c && r_s && r_a) r_req = $urandom_range(1) == 1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
